arb_req_gen: RTL and testbench
==============================

Name: arb_req_gen

Overview:
- Requester-side counterpart of the fixed-priority arbiter. It drives the arbiter's req vector and consumes its grant vector.
- Accepts transfer jobs, each tagged with a client index and a length. Raises that client's req and holds it until the granted transfer completes.
- Per-client state: one active job plus a one-deep pending slot.
- Checks that the grant protocol is legal. Used as a stimulus engine in the arbiter environment and as a reusable requester front-end.

Parameters:
- REQ_NUM, 4, number of clients; equals the arbiter's request width.
- LEN_W, 4, job length field width; a transfer lasts job_len+1 granted cycles.
- STAT_W, 16, width of the preemption statistics counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- job_valid  input  1  job offer this cycle
- job_client  input  $clog2(REQ_NUM)  target client index
- job_len  input  LEN_W  transfer length minus 1
- job_ready  output  1  combinational; high when the slot of job_client is empty
- grant  input  REQ_NUM  arbiter grant; registered in the arbiter, one-hot or zero
- req  output  REQ_NUM  request vector to the arbiter, registered
- busy  output  REQ_NUM  client in XFER state
- done  output  REQ_NUM  one-cycle pulse when a client's transfer completes
- err  output  1  sticky grant-protocol error
- stat_preempt  output  STAT_W  preemption event count (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): req=0, busy=0, done=0, err=0, stat_preempt=0; all slots empty; all clients IDLE.
- Job accept: a job is accepted when job_valid && job_ready. Out-of-range job_client (>= REQ_NUM) is ignored and job_ready=0 for it. Len is stored in the client's slot.
- Per-client FSM states:
  - IDLE:
    - slot full -> REQ next cycle; len moves from slot to active.
    - A job accepted into an empty IDLE client goes directly to active; the state becomes REQ on the next edge, and the slot stays empty.
  - REQ:
    - req[i]=1.
    - grant[i]=1 -> XFER with remaining=len+1; this first granted cycle does not count.
  - XFER:
    - req[i]=1, busy[i]=1.
    - Each cycle with grant[i]=1 decrements remaining.
    - Cycles with grant[i]=0 stall the transfer; the count holds and req stays high.
    - When grant[i]=1 and remaining==1: done[i]=1 on the next cycle.
      - Slot full -> load slot into active and go to REQ; req[i] stays high continuously.
      - Slot empty -> IDLE; req[i] falls on the same edge that done[i] rises.
- Slot: accepts a job while the client is in REQ or XFER, provided the slot is empty. A load from the slot and a new accept for the same client in the same cycle are both honoured; the new job lands in the freed slot.
- Latency: job accepted at edge N -> req[i]=1 after edge N+1.
- Error checks (err is set the cycle after the violation and stays set until reset):
  - grant not one-hot-or-zero;
  - grant[i]=1 while req[i]=0.
- Reset mid-transfer: all active and pending jobs are discarded and no done pulse is emitted.

Optional Feature:
- Macro ARB_REQ_GEN_STATS_EN.
- Defined: stat_preempt increments, saturating at all-ones, once per XFER transition from granted to not-granted for any client. If several clients transition in one cycle, the increment is by the number of such transitions.
- Undefined: stat_preempt is tied to 0 and the counter logic is not built.

Decomposition:
- Package arb_pkg holds:
  - REQ_NUM_DEF, the default client count;
  - client_state_e enum {IDLE, REQ, XFER};
  - the slot struct (valid bit, len field).
- Sub-module arb_req_client holds one client's FSM, slot, active length and remaining counter. It is instantiated REQ_NUM times in a generate loop.
- The top level keeps job routing, job_ready muxing, error checks and the stats counter.

Test Plan:
- Single job, client 2, len=3, grant[2] asserted the cycle after req[2] rises and held -> busy[2] for 4 granted cycles, done[2] pulses once, req[2]=0 the same cycle, err=0.
- Preemption: client 3 in XFER len=5; grant switches to client 0 for 3 cycles, then returns -> client 3 completes after exactly 6 granted cycles; stat_preempt=1 with the macro, 0 without it.
- Back-to-back: client 1 gets len=0 and then len=2 accepted while in XFER -> req[1] stays high throughout, done[1] pulses twice, job_ready for client 1 is low while the slot is full.
- Protocol error: drive grant=4'b0101, then separately grant[1] while req[1]=0 -> err rises the next cycle and stays high.
- Reset mid-XFER: rst_n low for 1 cycle during a len=7 transfer -> req=0, busy=0 immediately, no done pulse, next job accepted normally.
- Full fixed-priority arbiter in the loop, jobs for all 4 clients, len=1 -> done order 0,1,2,3, no err.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter requester front-end.
package arb_pkg;

  localparam int REQ_NUM_DEF = 4;
  localparam int LEN_W_DEF   = 4;
  localparam int LEN_MAX     = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER
  } client_state_e;

  // The length field is sized for the widest supported job; unused upper bits stay zero.
  typedef struct packed {
    logic               valid;
    logic [LEN_MAX-1:0] len;
  } slot_t;

  function automatic int unsigned count_ones(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n = n + {31'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/arb_req_client.sv
// One requester client: IDLE/REQ/XFER state machine, one-deep pending slot,
// active job length and remaining-beat counter.
module arb_req_client
  import arb_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic [LEN_W-1:0] job_len,
  input  logic             grant,
  output logic             slot_free,
  output logic             req,
  output logic             busy,
  output logic             done
);

  client_state_e      state;
  slot_t              slot;
  logic               act_pending;
  logic [LEN_MAX-1:0] active_len;
  logic [LEN_MAX:0]   remaining;
  logic               last_beat;
  logic               load_slot;
  logic               to_active;

  // A job offered to an idle client with nothing queued bypasses the slot.
  always_comb begin
    last_beat = (state == XFER) && grant && (remaining == (LEN_MAX+1)'(1));
    load_slot = slot.valid && (((state == IDLE) && !act_pending) || last_beat);
    to_active = accept && (state == IDLE) && !act_pending && !slot.valid;
  end

  assign slot_free = !slot.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot        <= '0;
      act_pending <= 1'b0;
      active_len  <= '0;
      remaining   <= '0;
      req         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (act_pending || slot.valid) begin
            state       <= REQ;
            req         <= 1'b1;
            act_pending <= 1'b0;
          end
        end
        REQ: begin
          if (grant) begin
            state     <= XFER;
            busy      <= 1'b1;
            remaining <= {1'b0, active_len} + (LEN_MAX+1)'(1);
          end
        end
        XFER: begin
          if (last_beat) begin
            done <= 1'b1;
            busy <= 1'b0;
            if (slot.valid) begin
              state <= REQ;
            end else begin
              state <= IDLE;
              req   <= 1'b0;
            end
          end else if (grant) begin
            remaining <= remaining - (LEN_MAX+1)'(1);
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

      if (load_slot) active_len <= slot.len;
      if (to_active) begin
        active_len  <= LEN_MAX'(job_len);
        act_pending <= 1'b1;
      end

      // A new accept wins over the slot being drained in the same cycle.
      if (accept && !to_active) begin
        slot.valid <= 1'b1;
        slot.len   <= LEN_MAX'(job_len);
      end else if (load_slot) begin
        slot.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/arb_req_gen.sv
// Requester front-end for the fixed-priority arbiter: job routing, grant protocol
// checking and, when ARB_REQ_GEN_STATS_EN is defined, a preemption counter.
module arb_req_gen
  import arb_pkg::*;
#(
  parameter int REQ_NUM = REQ_NUM_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int STAT_W  = 16,
  localparam int CW     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_valid,
  input  logic [CW-1:0]      job_client,
  input  logic [LEN_W-1:0]   job_len,
  output logic               job_ready,
  input  logic [REQ_NUM-1:0] grant,
  output logic [REQ_NUM-1:0] req,
  output logic [REQ_NUM-1:0] busy,
  output logic [REQ_NUM-1:0] done,
  output logic               err,
  output logic [STAT_W-1:0]  stat_preempt
);

  logic [REQ_NUM-1:0] slot_free;
  logic [REQ_NUM-1:0] accept;
  logic [REQ_NUM-1:0] req_q;
  logic               in_range;
  logic               grant_bad;

  assign in_range  = {1'b0, job_client} < (CW+1)'(REQ_NUM);
  assign job_ready = in_range && slot_free[job_client];

  for (genvar i = 0; i < REQ_NUM; i++) begin : g_client
    assign accept[i] = job_valid && in_range && slot_free[i] && (job_client == CW'(i));

    arb_req_client #(
      .LEN_W(LEN_W)
    ) u_client (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept   (accept[i]),
      .job_len  (job_len),
      .grant    (grant[i]),
      .slot_free(slot_free[i]),
      .req      (req[i]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

  // The arbiter registers its grant, so a grant is legal against last cycle's req.
  assign grant_bad = (count_ones(32'(grant)) > 1) || (|(grant & ~req_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      err   <= 1'b0;
    end else begin
      req_q <= req;
      if (grant_bad) err <= 1'b1;
    end
  end

`ifdef ARB_REQ_GEN_STATS_EN
  logic [REQ_NUM-1:0] grant_q;
  logic [REQ_NUM-1:0] preempt;
  logic [STAT_W:0]    stat_sum;
  logic [STAT_W-1:0]  stat_cnt;

  always_comb begin
    preempt  = busy & grant_q & ~grant;
    stat_sum = {1'b0, stat_cnt} + (STAT_W+1)'(count_ones(32'(preempt)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      stat_cnt <= '0;
    end else begin
      grant_q  <= grant;
      stat_cnt <= stat_sum[STAT_W] ? '1 : stat_sum[STAT_W-1:0];
    end
  end

  assign stat_preempt = stat_cnt;
`else
  assign stat_preempt = '0;
`endif

endmodule

// File: tb/tb_arb_req_gen.sv
// Scoreboard bench for arb_req_gen: expected completions are queued at stimulus time
// and a monitor checks each done pulse for client and number of granted beats.
module tb_arb_req_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid;
  logic [1:0]  job_client;
  logic [3:0]  job_len;
  logic        job_ready;
  logic [3:0]  grant;
  logic [3:0]  req;
  logic [3:0]  busy;
  logic [3:0]  done;
  logic        err;
  logic [15:0] stat_preempt;

  logic        use_arb;
  logic [3:0]  man_grant;
  logic [3:0]  arb_grant;

  typedef struct {
    int client;
    int beats;
  } exp_t;

  exp_t exp_q[$];
  int   beat_cnt[4];
  int   n_checks = 0;
  int   n_errors = 0;
  int   drops;
  int   dones;
  int   exp_stat;
  bit   found;

  always #5 clk = ~clk;

  assign grant = use_arb ? arb_grant : man_grant;

  // Reference registered fixed-priority arbiter, lowest index wins.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) arb_grant <= 4'b0;
    else        arb_grant <= req & (~req + 4'd1);
  end

  arb_req_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .job_valid   (job_valid),
    .job_client  (job_client),
    .job_len     (job_len),
    .job_ready   (job_ready),
    .grant       (grant),
    .req         (req),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .stat_preempt(stat_preempt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic expect_done(input int client, input int beats);
    exp_t e;
    e.client = client;
    e.beats  = beats;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input int client, input int len);
    @(negedge clk);
    job_valid  = 1'b1;
    job_client = 2'(client);
    job_len    = 4'(len);
    #1;
    checkOutput($sformatf("job_ready_c%0d", client), job_ready, 1);
    @(posedge clk);
    #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_signal(input string name, input bit is_busy, input int c);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk);
      hit = is_busy ? busy[c] : req[c];
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: timeout, got 0 expected 1", name);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 120 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: timeout, pending completions %0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_req", req, 0);
    checkOutput("rst_busy", busy, 0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) beat_cnt[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pops the next expected completion on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) beat_cnt[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (done[i]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL done_unexpected: got done on client %0d expected none", i);
          end else begin
            e = exp_q.pop_front();
            checkOutput("done_client", i, e.client);
            checkOutput($sformatf("done_beats_c%0d", i), beat_cnt[i], e.beats);
          end
          beat_cnt[i] = 0;
        end
        if (busy[i] && grant[i]) beat_cnt[i]++;
      end
    end
  end

  initial begin
`ifdef ARB_REQ_GEN_STATS_EN
    exp_stat = 1;
`else
    exp_stat = 0;
`endif
    use_arb    = 1'b1;
    man_grant  = 4'b0;
    job_valid  = 1'b0;
    job_client = 2'd0;
    job_len    = 4'd0;

    repeat (2) @(negedge clk);
    checkOutput("reset_req", req, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_stat", stat_preempt, 0);
    rst_n = 1'b1;

    // Single job with one-cycle accept-to-request latency.
    $display("[TB] single job, client 2, len 3");
    expect_done(2, 4);
    applyStimulus(2, 3);
    checkOutput("latency_req_edge_n", req[2], 0);
    @(posedge clk);
    #1;
    checkOutput("latency_req_edge_n1", req[2], 1);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      found = done[2];
    end
    checkOutput("single_done_seen", found, 1);
    checkOutput("single_req_falls_with_done", req[2], 0);
    checkOutput("single_err", err, 0);
    wait_drain("single_drain");

    // Second job queued in the slot while the first is still requesting.
    $display("[TB] back-to-back, client 1");
    expect_done(1, 1);
    expect_done(1, 3);
    applyStimulus(1, 0);
    wait_signal("b2b_req_rise", 1'b0, 1);
    applyStimulus(1, 2);
    job_client = 2'd1;
    #1;
    checkOutput("b2b_ready_slot_full", job_ready, 0);
    drops = 0;
    dones = 0;
    for (int k = 0; k < 40 && dones < 2; k++) begin
      @(negedge clk);
      if (done[1]) dones++;
      else if (!req[1]) drops++;
    end
    checkOutput("b2b_done_count", dones, 2);
    checkOutput("b2b_req_drops", drops, 0);
    checkOutput("b2b_req_after_last", req[1], 0);
    wait_drain("b2b_drain");

    // Client 0 preempts client 3 mid-transfer.
    $display("[TB] preemption, client 3 len 5 by client 0 len 1");
    expect_done(0, 2);
    expect_done(3, 6);
    applyStimulus(3, 5);
    wait_signal("pre_busy3", 1'b1, 3);
    applyStimulus(0, 1);
    wait_drain("pre_drain");
    checkOutput("pre_stat", stat_preempt, exp_stat);
    checkOutput("pre_err", err, 0);

    // All clients at once complete in priority order.
    $display("[TB] all clients, len 1");
    for (int c = 0; c < 4; c++) expect_done(c, 2);
    for (int c = 0; c < 4; c++) applyStimulus(c, 1);
    wait_drain("loop_drain");
    checkOutput("loop_err", err, 0);

    // Reset in the middle of a long transfer.
    $display("[TB] reset mid transfer");
    applyStimulus(1, 7);
    wait_signal("rst_busy1", 1'b1, 1);
    repeat (2) @(negedge clk);
    pulse_reset();
    checkOutput("rst_stat_cleared", stat_preempt, 0);
    checkOutput("rst_err", err, 0);
    repeat (5) @(negedge clk);
    expect_done(1, 1);
    applyStimulus(1, 0);
    wait_drain("rst_next_job");

    // Protocol violations with a hand-driven grant.
    $display("[TB] grant protocol errors");
    use_arb   = 1'b0;
    man_grant = 4'b0;
    applyStimulus(0, 7);
    applyStimulus(2, 7);
    repeat (3) @(negedge clk);
    checkOutput("perr_req_pattern", req, 4'b0101);
    checkOutput("perr_err_before", err, 0);
    man_grant = 4'b0101;
    @(negedge clk);
    man_grant = 4'b0;
    checkOutput("perr_multi_grant", err, 1);
    pulse_reset();
    checkOutput("perr_err_cleared", err, 0);
    man_grant = 4'b0010;
    @(negedge clk);
    man_grant = 4'b0;
    checkOutput("perr_grant_no_req", err, 1);
    repeat (3) @(negedge clk);
    checkOutput("perr_sticky", err, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
